fc_train_seq: RTL and testbench

FC_TRAIN_SEQ -- requirements
Module: fc_train_seq

---
 rtl/fc_train_seq.sv | 206 ++++++++++++++++++++
 tb/tb_fc_train_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fc_train_seq.sv
// Training-pass sequencer for the FC layers: walks forward, backward and weight-gradient
// phases across all layers, driving operand fetch and datapath mux selects.
module fc_train_seq #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned N_LAYERS = 4,
  parameter int unsigned LAYER_W  = 2
) (
  input  logic               clk,
  input  logic               fsm_rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         stride_mode,
  input  logic [CNT_W-1:0]   len_fp,
  input  logic [CNT_W-1:0]   len_bp,
  input  logic [CNT_W-1:0]   len_wg,
  output logic [1:0]         phase,
  output logic [LAYER_W-1:0] layer,
  output logic               select0,
  output logic               select1,
  output logic               in_en,
  output logic               busy,
  output logic               bp_done,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FP_FC = 2'b01,
    BP_FC = 2'b10,
    WG    = 2'b11
  } phase_e;

  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(N_LAYERS - 1);

  phase_e             state_r, state_s;
  logic [LAYER_W-1:0] layer_r, layer_s;
  logic [CNT_W-1:0]   count_r, count_s;
  logic [1:0]         mode_r, mode_s;
  logic [CNT_W-1:0]   len_fp_r, len_fp_s;
  logic [CNT_W-1:0]   len_bp_r, len_bp_s;
  logic [CNT_W-1:0]   len_wg_r, len_wg_s;
  logic [CNT_W-1:0]   cur_len_s, nxt_len_s;
  logic               terminal_s, last_layer_s;

  logic [1:0]         sel_r, sel_s;
  logic               in_en_r, in_en_s;
  logic               busy_r, busy_s;
  logic               bp_done_r, bp_done_s;
  logic               done_r, done_s;

  // Sequencer state, counter and pass-configuration registers.
  always_ff @(posedge clk or negedge fsm_rst_n) begin
    if (!fsm_rst_n) begin
      state_r  <= IDLE;
      layer_r  <= '0;
      count_r  <= '0;
      mode_r   <= 2'b00;
      len_fp_r <= '0;
      len_bp_r <= '0;
      len_wg_r <= '0;
    end else begin
      state_r  <= state_s;
      layer_r  <= layer_s;
      count_r  <= count_s;
      mode_r   <= mode_s;
      len_fp_r <= len_fp_s;
      len_bp_r <= len_bp_s;
      len_wg_r <= len_wg_s;
    end
  end

  // Next-state: phase/layer stepping, cycle counting, start latch and abort.
  always_comb begin
    state_s  = state_r;
    layer_s  = layer_r;
    count_s  = count_r;
    mode_s   = mode_r;
    len_fp_s = len_fp_r;
    len_bp_s = len_bp_r;
    len_wg_s = len_wg_r;

    case (state_r)
      FP_FC:   cur_len_s = len_fp_r;
      BP_FC:   cur_len_s = len_bp_r;
      WG:      cur_len_s = len_wg_r;
      default: cur_len_s = '0;
    endcase
    terminal_s = (count_r == cur_len_s);
    // Forward pass ends on the top layer; the backward phases end on layer 0.
    if (state_r == FP_FC) begin
      last_layer_s = (layer_r == LAST_LAYER);
    end else begin
      last_layer_s = (layer_r == '0);
    end

    case (state_r)
      IDLE: begin
        if (start && !abort) begin
          state_s  = FP_FC;
          layer_s  = '0;
          count_s  = '0;
          mode_s   = stride_mode;
          len_fp_s = len_fp;
          len_bp_s = len_bp;
          len_wg_s = len_wg;
        end else begin
          layer_s = '0;
          count_s = '0;
        end
      end
      FP_FC, BP_FC, WG: begin
        if (abort) begin
          state_s = IDLE;
          layer_s = '0;
          count_s = '0;
        end else if (!terminal_s) begin
          count_s = count_r + CNT_W'(1);
        end else if (!last_layer_s) begin
          count_s = '0;
          if (state_r == FP_FC) begin
            layer_s = layer_r + LAYER_W'(1);
          end else begin
            layer_s = layer_r - LAYER_W'(1);
          end
        end else begin
          count_s = '0;
          case (state_r)
            FP_FC: begin
              state_s = BP_FC;
              layer_s = LAST_LAYER;
            end
            BP_FC: begin
              state_s = WG;
              layer_s = LAST_LAYER;
            end
            default: begin
              state_s = IDLE;
              layer_s = '0;
            end
          endcase
        end
      end
      default: begin
        state_s = IDLE;
        layer_s = '0;
        count_s = '0;
      end
    endcase
  end

  // Output values for the upcoming cycle, derived from the next state.
  always_comb begin
    case (state_s)
      FP_FC:   nxt_len_s = len_fp_s;
      BP_FC:   nxt_len_s = len_bp_s;
      WG:      nxt_len_s = len_wg_s;
      default: nxt_len_s = '0;
    endcase

    if (state_s != IDLE) begin
      busy_s  = 1'b1;
      in_en_s = (count_s != nxt_len_s);
      case (mode_s)
        2'b00:   sel_s = 2'b00;
        2'b01:   sel_s = 2'b11;
        2'b10:   sel_s = 2'b10;
        2'b11:   sel_s = 2'b01;
        default: sel_s = 2'b00;
      endcase
    end else begin
      busy_s  = 1'b0;
      in_en_s = 1'b0;
      sel_s   = 2'b00;
    end

    bp_done_s = (state_r == BP_FC) && (state_s == WG);
    done_s    = (state_r == WG) && (state_s == IDLE) && !abort;
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge fsm_rst_n) begin
    if (!fsm_rst_n) begin
      sel_r     <= 2'b00;
      in_en_r   <= 1'b0;
      busy_r    <= 1'b0;
      bp_done_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      sel_r     <= sel_s;
      in_en_r   <= in_en_s;
      busy_r    <= busy_s;
      bp_done_r <= bp_done_s;
      done_r    <= done_s;
    end
  end

  assign phase   = state_r;
  assign layer   = layer_r;
  assign select1 = sel_r[1];
  assign select0 = sel_r[0];
  assign in_en   = in_en_r;
  assign busy    = busy_r;
  assign bp_done = bp_done_r;
  assign done    = done_r;

endmodule

// File: tb/tb_fc_train_seq.sv
// Directed bench for fc_train_seq with two FC layers; cycle n is the period after edge n-1
// when the start request is sampled at edge 0.
module tb_fc_train_seq;

  logic       clk;
  logic       fsm_rst_n;
  logic       start;
  logic       abort;
  logic [1:0] stride_mode;
  logic [7:0] len_fp, len_bp, len_wg;
  logic [1:0] phase;
  logic [0:0] layer;
  logic       select0, select1, in_en, busy, bp_done, done;
  logic [8:0] obs;

  int total = 0;
  int bad   = 0;

  fc_train_seq #(.CNT_W(8), .N_LAYERS(2), .LAYER_W(1)) dut (
    .clk(clk), .fsm_rst_n(fsm_rst_n), .start(start), .abort(abort),
    .stride_mode(stride_mode), .len_fp(len_fp), .len_bp(len_bp), .len_wg(len_wg),
    .phase(phase), .layer(layer), .select0(select0), .select1(select1),
    .in_en(in_en), .busy(busy), .bp_done(bp_done), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {phase, layer, select1, select0, in_en, busy, bp_done, done};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int c, input logic [8:0] o, input logic [8:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s cyc=%0d obs=%b exp=%b (phase,layer,sel1,sel0,in_en,busy,bp_done,done)",
             tag, c, o, e);
    end
  endtask

  // Two layers, all lengths 3: FP 1-8, BP 9-16, WG 17-24, done at 25.
  function automatic logic [8:0] exp031(input int c, input logic [1:0] sel, input int abort_at);
    logic [1:0] ph;
    logic       ly, ie, bz;
    int         i;
    ph = 2'b00; ly = 1'b0; ie = 1'b0; bz = 1'b0;
    if (abort_at != 0 && c > abort_at) return 9'd0;
    if (c >= 1 && c <= 24) begin
      ph = (c <= 8) ? 2'b01 : (c <= 16) ? 2'b10 : 2'b11;
      i  = (c - 1) % 8;
      ly = (ph == 2'b01) ? (i >= 4) : !(i >= 4);
      ie = (c % 4) != 0;
      bz = 1'b1;
    end
    return {ph, ly, (bz ? sel : 2'b00), ie, bz, (c == 17), (c == 25)};
  endfunction

  // len_fp=0, len_bp=5, len_wg=1: FP 1-2, BP 3-14, WG 15-18, done at 19.
  function automatic logic [8:0] exp033(input int c, input logic [1:0] sel);
    logic [1:0] ph;
    logic       ly, ie, bz;
    ph = 2'b00; ly = 1'b0; ie = 1'b0; bz = 1'b0;
    if (c >= 1 && c <= 2) begin
      ph = 2'b01; ly = (c == 2); bz = 1'b1;
    end else if (c >= 3 && c <= 14) begin
      ph = 2'b10; ly = (c <= 8); ie = (c != 8) && (c != 14); bz = 1'b1;
    end else if (c >= 15 && c <= 18) begin
      ph = 2'b11; ly = (c <= 16); ie = (c == 15) || (c == 17); bz = 1'b1;
    end
    return {ph, ly, (bz ? sel : 2'b00), ie, bz, (c == 15), (c == 19)};
  endfunction

  task automatic launch(input logic [1:0] m, input logic [7:0] lf, input logic [7:0] lb,
                        input logic [7:0] lw);
    stride_mode = m; len_fp = lf; len_bp = lb; len_wg = lw;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pass_check(input string tag, input logic [1:0] sel, input int abort_at,
                            input int last_c, input int restart_c, input bit wiggle);
    for (int c = 1; c <= last_c; c++) begin
      chk(tag, c, obs, exp031(c, sel, abort_at));
      start = (c == 3) || (c == 20) || (c == restart_c);
      abort = (c == abort_at);
      if (c == restart_c) begin
        stride_mode = 2'b00; len_fp = 8'd3; len_bp = 8'd3; len_wg = 8'd3;
      end
      if (wiggle && c == 5) begin
        stride_mode = ~stride_mode; len_fp = 8'd0; len_bp = 8'd7; len_wg = 8'd0;
      end
      step();
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    fsm_rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    stride_mode = 2'b00; len_fp = 8'd0; len_bp = 8'd0; len_wg = 8'd0;
    #2;
    chk("reset_async", 0, obs, 9'd0);
    step();
    chk("reset_held", 0, obs, 9'd0);
    fsm_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("reset_exit_idle", k, obs, 9'd0);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_in_idle", 0, obs, 9'd0);

    // Basic pass with ignored start pulses at cycles 3 and 20.
    launch(2'b00, 8'd3, 8'd3, 8'd3);
    pass_check("pass_m00", 2'b00, 0, 26, 0, 1'b0);

    // stride_mode 10 with inputs changed mid-pass.
    launch(2'b10, 8'd3, 8'd3, 8'd3);
    pass_check("pass_m10_latch", 2'b10, 0, 26, 0, 1'b1);

    // Unequal lengths, zero-length forward phase, stride_mode 01.
    launch(2'b01, 8'd0, 8'd5, 8'd1);
    for (int c = 1; c <= 21; c++) begin
      chk("pass_lens", c, obs, exp033(c, 2'b11));
      step();
    end

    // Abort in BP at cycle 10, restart at 12 for a clean pass.
    launch(2'b11, 8'd3, 8'd3, 8'd3);
    pass_check("abort_m11", 2'b01, 10, 12, 12, 1'b0);
    pass_check("after_abort", 2'b00, 0, 26, 0, 1'b0);

    // Asynchronous reset in the middle of the backward phase.
    launch(2'b10, 8'd3, 8'd3, 8'd3);
    pass_check("pre_reset", 2'b10, 0, 12, 0, 1'b0);
    #3;
    fsm_rst_n = 1'b0;
    #1;
    chk("reset_mid_bp", 13, obs, 9'd0);
    step();
    chk("reset_mid_bp_held", 14, obs, 9'd0);
    #2;
    fsm_rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("no_resume", k, obs, 9'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
